clk_gen_multi: RTL and testbench
================================

Name: clk_gen_multi

Overview:
- Synthesizable, parametrised multi-channel clock generator for the clk_rst bench area.
- Derives NUM_CH divided clocks from one reference clock, each with its own programmable half-period, glitch-free enable/disable and a per-channel reset that releases after a set number of output clock edges.
- Replaces free-running, delay-based clock models, so clock-domain tests can reconfigure frequencies mid-simulation.

Parameters:
- NUM_CH, 4: number of independent output clock channels.
- DIV_W, 8: width of each half-period field, in reference cycles.
- DEF_HALF, 1: active half-period loaded on reset.
- RST_HOLD, 4: count of output rising edges before rst_out releases (range 1..255).

Ports:
- clk  in  1  reference clock; all logic on its rising edge.
- arst  in  1  reset, synchronous, active-high.
- ch_en  in  NUM_CH  per-channel run request.
- cfg_load  in  NUM_CH  per-channel one-cycle strobe; captures cfg_half slice into shadow register.
- cfg_half  in  NUM_CH*DIV_W  half-period per channel; channel i uses bits [i*DIV_W +: DIV_W].
- clk_out  out  NUM_CH  generated clocks (registered).
- clk_rise  out  NUM_CH  one-cycle strobe, high in the cycle clk_out goes 0->1.
- rst_out  out  NUM_CH  per-channel reset, active-high.
- pending  out  NUM_CH  shadow loaded but not yet applied.

Behaviour:
- Reset: arst is synchronous, active-high. While high, on every clk edge all channels go to:
  - state OFF, cnt=0, clk_out=0, clk_rise=0, rst_out=1, pending=0;
  - active=shadow=DEF_HALF, rise counter=0.
- arst dominates every other input. Mid-operation reset forces clk_out low immediately, even mid-high-phase.
- Half-period clamp: a cfg_half of 0 is stored as 1. Output period = 2*active reference cycles; half=1 gives clk/2.
- Per-channel FSM, state OFF:
  - clk_out=0, cnt=0, rst_out=1.
  - ch_en=1 -> RUN next cycle, with cnt=0 and rise counter=0.
- Per-channel FSM, state RUN:
  - cnt increments each cycle.
  - When cnt==active-1: clk_out toggles on the next edge and cnt returns to 0.
  - First rising edge of clk_out is exactly `active` cycles after entering RUN.
- Per-channel FSM, ch_en=0 while in RUN:
  - if clk_out=0: go to OFF next cycle;
  - if clk_out=1: go to STOP.
- Per-channel FSM, state STOP:
  - Keep counting; at the falling toggle go to OFF.
  - rst_out=1 in STOP. No shortened high pulse is ever produced.
  - ch_en re-asserted during STOP has no effect until OFF is reached; OFF->RUN then proceeds normally.
- Config update:
  - cfg_load[i] sets shadow and sets pending=1 on the next edge.
  - In OFF: active<=shadow on the following cycle, then pending clears.
  - In RUN/STOP: active<=shadow only on the cycle clk_out toggles 1->0; the new value governs that low phase onward.
  - cfg_load in the same cycle as a toggle: the toggle uses the old active; the new value applies at the next falling toggle.
  - A second cfg_load before application overwrites the shadow, and only the last value applies.
- rst_out:
  - 1 in OFF/STOP and on entering RUN.
  - Rise counter saturates at RST_HOLD.
  - rst_out drops to 0 in the same cycle as the RST_HOLD-th clk_rise, and stays 0 while in RUN.
- Channels are fully independent and share only clk/arst.
- clk_out has no combinational path from any input.

Decomposition:
- Package clk_gen_pkg:
  - chan_state_e enum {OFF, RUN, STOP};
  - localparam for the rise-counter width (8 bits);
  - function clamp_half() mapping 0->1.
- Sub-module clk_gen_chan: one channel (FSM, cnt, shadow/active, rise counter), parameters DIV_W, DEF_HALF, RST_HOLD.
- Top clk_gen_multi is a generate loop of NUM_CH instances plus bus slicing.

Test Plan:
- Reset default: arst 3 cycles, then ch_en[0]=1 -> first clk_rise[0] 1 cycle after RUN entry; clk_out[0] period 2 (clk/2); rst_out[0] drops on the 4th rise.
- Program: cfg_half[1]=5 with cfg_load while OFF, then enable -> clk_out[1] 5 cycles low, 5 high, period 10; pending[1] high for exactly 1 cycle.
- Live change: ch2 running at half=3, load 7 during its high phase -> the current high phase stays 3 cycles; from the falling edge the phases are 7; pending clears at that edge.
- Glitch-free stop: drop ch_en[3] 1 cycle into a 6-cycle high phase -> clk_out stays high the remaining 5 cycles, then OFF; rst_out[3]=1 from the STOP entry.
- Zero clamp and simultaneity: cfg_half=0 loaded on the same cycle as a toggle -> the toggle uses the old value; afterwards the period is 2.
- Mid-run reset: arst pulse while all 4 channels are high -> next edge all clk_out=0, rst_out=4'b1111, active=DEF_HALF.

Source files
------------

// File: rtl/clk_gen_pkg.sv
// Shared types and helpers for the multi-channel clock generator.
// Channel FSM states, rise-counter width and the half-period clamp.
package clk_gen_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } chan_state_e;

  localparam int RISE_W = 8;

  // A half-period of zero would never toggle, so it is stored as one.
  function automatic logic [31:0] clamp_half(input logic [31:0] half);
    return (half == 32'd0) ? 32'd1 : half;
  endfunction

endpackage

// File: rtl/clk_gen_chan.sv
// One generated clock channel: OFF/RUN/STOP FSM, half-period counter,
// shadow/active half-period registers and a rise-counted reset output.
module clk_gen_chan
  import clk_gen_pkg::*;
#(
  parameter int DIV_W    = 8,
  parameter int DEF_HALF = 1,
  parameter int RST_HOLD = 4
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             ch_en,
  input  logic             cfg_load,
  input  logic [DIV_W-1:0] cfg_half,
  output logic             clk_out,
  output logic             clk_rise,
  output logic             rst_out,
  output logic             pending
);

  localparam logic [DIV_W-1:0]  ONE       = DIV_W'(1);
  localparam logic [DIV_W-1:0]  DEF_VAL   = DIV_W'(DEF_HALF);
  localparam logic [RISE_W-1:0] HOLD_SAT  = RISE_W'(RST_HOLD);
  localparam logic [RISE_W-1:0] HOLD_LAST = RISE_W'(RST_HOLD - 1);

  chan_state_e       state, state_nxt;
  logic [DIV_W-1:0]  cnt, cnt_nxt;
  logic [DIV_W-1:0]  active, active_nxt;
  logic [DIV_W-1:0]  shadow, shadow_nxt;
  logic [DIV_W-1:0]  half_clamped;
  logic [RISE_W-1:0] rise_cnt, rise_cnt_nxt;
  logic              clk_out_nxt, clk_rise_nxt, rst_out_nxt, pending_nxt;
  logic              hit, stop_low, toggle, rise, fall, apply;

  assign half_clamped = DIV_W'(clamp_half(32'(cfg_half)));

  // A low-phase disable goes straight to OFF and suppresses any pending rise.
  assign hit      = (cnt == active - ONE);
  assign stop_low = (state == RUN) && !ch_en && !clk_out;
  assign toggle   = ((state == RUN) && !stop_low && hit) || ((state == STOP) && hit);
  assign rise     = toggle && !clk_out;
  assign fall     = toggle && clk_out;
  // New half-periods take effect only at a falling edge (or while idle),
  // so a high phase is never shortened or stretched mid-way.
  assign apply    = pending && ((state == OFF) || fall);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (arst) state <= OFF;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      OFF:     if (ch_en) state_nxt = RUN;
      RUN:     if (!ch_en) state_nxt = (clk_out && !fall) ? STOP : OFF;
      STOP:    if (fall) state_nxt = OFF;
      default: state_nxt = OFF;
    endcase
  end

  // NOTE: every signal gets a default before the conditionals; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    cnt_nxt      = '0;
    clk_out_nxt  = 1'b0;
    clk_rise_nxt = rise;
    rise_cnt_nxt = rise_cnt;
    rst_out_nxt  = rst_out;
    active_nxt   = apply ? shadow : active;
    shadow_nxt   = cfg_load ? half_clamped : shadow;
    pending_nxt  = cfg_load | (pending & ~apply);

    if ((state != OFF) && (state_nxt != OFF)) begin
      cnt_nxt     = toggle ? '0 : cnt + ONE;
      clk_out_nxt = clk_out ^ toggle;
    end

    if (state == OFF)
      rise_cnt_nxt = '0;
    else if (rise && (rise_cnt != HOLD_SAT))
      rise_cnt_nxt = rise_cnt + RISE_W'(1);

    if ((state_nxt != RUN) || (state == OFF))
      rst_out_nxt = 1'b1;
    else if (rise && (rise_cnt >= HOLD_LAST))
      rst_out_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      cnt      <= '0;
      clk_out  <= 1'b0;
      clk_rise <= 1'b0;
      rst_out  <= 1'b1;
      pending  <= 1'b0;
      active   <= DEF_VAL;
      shadow   <= DEF_VAL;
      rise_cnt <= '0;
    end else begin
      cnt      <= cnt_nxt;
      clk_out  <= clk_out_nxt;
      clk_rise <= clk_rise_nxt;
      rst_out  <= rst_out_nxt;
      pending  <= pending_nxt;
      active   <= active_nxt;
      shadow   <= shadow_nxt;
      rise_cnt <= rise_cnt_nxt;
    end
  end

endmodule

// File: rtl/clk_gen_multi.sv
// Multi-channel clock generator: NUM_CH independent divided clocks from clk,
// each with its own half-period, glitch-free stop and rise-counted reset.
module clk_gen_multi #(
  parameter int NUM_CH   = 4,
  parameter int DIV_W    = 8,
  parameter int DEF_HALF = 1,
  parameter int RST_HOLD = 4
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH-1:0]       cfg_load,
  input  logic [NUM_CH*DIV_W-1:0] cfg_half,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       clk_rise,
  output logic [NUM_CH-1:0]       rst_out,
  output logic [NUM_CH-1:0]       pending
);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    clk_gen_chan #(
      .DIV_W   (DIV_W),
      .DEF_HALF(DEF_HALF),
      .RST_HOLD(RST_HOLD)
    ) u_chan (
      .clk     (clk),
      .arst    (arst),
      .ch_en   (ch_en[gi]),
      .cfg_load(cfg_load[gi]),
      .cfg_half(cfg_half[gi*DIV_W +: DIV_W]),
      .clk_out (clk_out[gi]),
      .clk_rise(clk_rise[gi]),
      .rst_out (rst_out[gi]),
      .pending (pending[gi])
    );
  end

endmodule

// File: tb/tb_clk_gen_multi.sv
// Directed bench for clk_gen_multi; expected waveforms are hand-derived
// phase windows, sampled on the falling edge of clk.
module tb_clk_gen_multi;

  localparam int NUM_CH = 4;
  localparam int DIV_W  = 8;

  logic                    clk = 1'b0;
  logic                    arst;
  logic [NUM_CH-1:0]       ch_en;
  logic [NUM_CH-1:0]       cfg_load;
  logic [NUM_CH*DIV_W-1:0] cfg_half;
  logic [NUM_CH-1:0]       clk_out;
  logic [NUM_CH-1:0]       clk_rise;
  logic [NUM_CH-1:0]       rst_out;
  logic [NUM_CH-1:0]       pending;

  int total = 0;
  int bad   = 0;

  clk_gen_multi #(
    .NUM_CH  (NUM_CH),
    .DIV_W   (DIV_W),
    .DEF_HALF(1),
    .RST_HOLD(4)
  ) dut (
    .clk     (clk),
    .arst    (arst),
    .ch_en   (ch_en),
    .cfg_load(cfg_load),
    .cfg_half(cfg_half),
    .clk_out (clk_out),
    .clk_rise(clk_rise),
    .rst_out (rst_out),
    .pending (pending)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    arst     = 1'b1;
    ch_en    = '0;
    cfg_load = '0;
    cfg_half = '0;
    repeat (3) @(negedge clk);
    arst = 1'b0;
  endtask

  // Reset must dominate enable and load requests.
  task automatic test_reset();
    arst     = 1'b1;
    ch_en    = '1;
    cfg_load = '1;
    cfg_half = '0;
    repeat (3) @(negedge clk);
    total++; if (clk_out !== 4'b0000) begin bad++; $display("FAIL reset_clk_out got=%b exp=0000", clk_out); end
    total++; if (rst_out !== 4'b1111) begin bad++; $display("FAIL reset_rst_out got=%b exp=1111", rst_out); end
    total++; if (pending !== 4'b0000) begin bad++; $display("FAIL reset_pending got=%b exp=0000", pending); end
    total++; if (clk_rise !== 4'b0000) begin bad++; $display("FAIL reset_clk_rise got=%b exp=0000", clk_rise); end
    arst     = 1'b0;
    ch_en    = '0;
    cfg_load = '0;
    @(negedge clk);
    total++; if (clk_out !== 4'b0000) begin bad++; $display("FAIL post_reset_clk_out got=%b exp=0000", clk_out); end
    total++; if (rst_out !== 4'b1111) begin bad++; $display("FAIL post_reset_rst_out got=%b exp=1111", rst_out); end
  endtask

  // Default half=1: clk/2, first rise one cycle after RUN entry, rst_out drops on 4th rise.
  task automatic test_default();
    do_reset();
    ch_en[0] = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      total++; if (clk_out[0] !== k[0]) begin bad++; $display("FAIL default_clk_out k=%0d got=%b exp=%b", k, clk_out[0], k[0]); end
      total++; if (clk_rise[0] !== k[0]) begin bad++; $display("FAIL default_clk_rise k=%0d got=%b exp=%b", k, clk_rise[0], k[0]); end
      total++; if (rst_out[0] !== (k < 7)) begin bad++; $display("FAIL default_rst_out k=%0d got=%b exp=%b", k, rst_out[0], (k < 7)); end
    end
    total++; if (clk_out[3:1] !== 3'b000) begin bad++; $display("FAIL default_others_idle got=%b exp=000", clk_out[3:1]); end
  endtask

  // Half=5 loaded while OFF: pending for one cycle, then 5 low / 5 high.
  task automatic test_program();
    do_reset();
    cfg_half[1*DIV_W +: DIV_W] = 8'd5;
    cfg_load[1] = 1'b1;
    @(negedge clk);
    total++; if (pending[1] !== 1'b1) begin bad++; $display("FAIL program_pending_set got=%b exp=1", pending[1]); end
    cfg_load[1] = 1'b0;
    @(negedge clk);
    total++; if (pending[1] !== 1'b0) begin bad++; $display("FAIL program_pending_clr got=%b exp=0", pending[1]); end
    ch_en[1] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      logic eo, er;
      @(negedge clk);
      eo = ((k >= 5) && (k < 10)) || (k >= 15);
      er = (k == 5) || (k == 15);
      total++; if (clk_out[1] !== eo) begin bad++; $display("FAIL program_clk_out k=%0d got=%b exp=%b", k, clk_out[1], eo); end
      total++; if (clk_rise[1] !== er) begin bad++; $display("FAIL program_clk_rise k=%0d got=%b exp=%b", k, clk_rise[1], er); end
    end
  endtask

  // Half=3 running, load 7 during a high phase: change lands at the falling edge.
  task automatic test_live_change();
    do_reset();
    cfg_half[2*DIV_W +: DIV_W] = 8'd3;
    cfg_load[2] = 1'b1;
    @(negedge clk);
    cfg_load[2] = 1'b0;
    @(negedge clk);
    ch_en[2] = 1'b1;
    for (int k = 0; k < 28; k++) begin
      logic eo, ep;
      @(negedge clk);
      eo = ((k >= 3) && (k < 6)) || ((k >= 9) && (k < 12)) || ((k >= 19) && (k < 26));
      ep = (k == 10) || (k == 11);
      total++; if (clk_out[2] !== eo) begin bad++; $display("FAIL live_clk_out k=%0d got=%b exp=%b", k, clk_out[2], eo); end
      total++; if (pending[2] !== ep) begin bad++; $display("FAIL live_pending k=%0d got=%b exp=%b", k, pending[2], ep); end
      if (k == 9) begin
        cfg_half[2*DIV_W +: DIV_W] = 8'd7;
        cfg_load[2] = 1'b1;
      end else begin
        cfg_load[2] = 1'b0;
      end
    end
  endtask

  // Half=6; disable one cycle into the 4th high phase, re-enable during STOP.
  task automatic test_stop();
    do_reset();
    cfg_half[3*DIV_W +: DIV_W] = 8'd6;
    cfg_load[3] = 1'b1;
    @(negedge clk);
    cfg_load[3] = 1'b0;
    @(negedge clk);
    ch_en[3] = 1'b1;
    for (int k = 0; k < 59; k++) begin
      logic eo, er;
      @(negedge clk);
      eo = ((k >= 6) && (k < 12)) || ((k >= 18) && (k < 24)) || ((k >= 30) && (k < 36)) ||
           ((k >= 42) && (k < 48)) || (k >= 55);
      er = (k != 42);
      total++; if (clk_out[3] !== eo) begin bad++; $display("FAIL stop_clk_out k=%0d got=%b exp=%b", k, clk_out[3], eo); end
      total++; if (rst_out[3] !== er) begin bad++; $display("FAIL stop_rst_out k=%0d got=%b exp=%b", k, rst_out[3], er); end
      if (k == 42) ch_en[3] = 1'b0;
      if (k == 45) ch_en[3] = 1'b1;
    end
  endtask

  // Half=2; load 9 on a falling toggle, then 0 on a rising toggle: last value (clamped 1) applies at next fall.
  task automatic test_clamp();
    do_reset();
    cfg_half[1*DIV_W +: DIV_W] = 8'd2;
    cfg_load[1] = 1'b1;
    @(negedge clk);
    cfg_load[1] = 1'b0;
    @(negedge clk);
    ch_en[1] = 1'b1;
    for (int k = 0; k < 18; k++) begin
      logic eo, ep;
      @(negedge clk);
      if (k < 12) eo = ((k >= 2) && (k < 4)) || ((k >= 6) && (k < 8)) || ((k >= 10) && (k < 12));
      else        eo = k[0];
      ep = (k >= 8) && (k < 12);
      total++; if (clk_out[1] !== eo) begin bad++; $display("FAIL clamp_clk_out k=%0d got=%b exp=%b", k, clk_out[1], eo); end
      total++; if (pending[1] !== ep) begin bad++; $display("FAIL clamp_pending k=%0d got=%b exp=%b", k, pending[1], ep); end
      if (k == 7) begin
        cfg_half[1*DIV_W +: DIV_W] = 8'd9;
        cfg_load[1] = 1'b1;
      end else if (k == 9) begin
        cfg_half[1*DIV_W +: DIV_W] = 8'd0;
        cfg_load[1] = 1'b1;
      end else begin
        cfg_load[1] = 1'b0;
      end
    end
  endtask

  // All channels at half=3, reset during a common high phase; restart uses DEF_HALF.
  task automatic test_midrun_reset();
    do_reset();
    cfg_half = {4{8'd3}};
    cfg_load = 4'b1111;
    @(negedge clk);
    cfg_load = 4'b0000;
    @(negedge clk);
    ch_en = 4'b1111;
    for (int k = 0; k < 23; k++) begin
      logic [3:0] eo, er;
      @(negedge clk);
      eo = ((k >= 3) && (((k / 3) % 2) == 1)) ? 4'b1111 : 4'b0000;
      er = (k >= 21) ? 4'b0000 : 4'b1111;
      total++; if (clk_out !== eo) begin bad++; $display("FAIL midrun_clk_out k=%0d got=%b exp=%b", k, clk_out, eo); end
      total++; if (rst_out !== er) begin bad++; $display("FAIL midrun_rst_out k=%0d got=%b exp=%b", k, rst_out, er); end
    end
    arst = 1'b1;
    @(negedge clk);
    total++; if (clk_out !== 4'b0000) begin bad++; $display("FAIL midrun_arst_clk_out got=%b exp=0000", clk_out); end
    total++; if (rst_out !== 4'b1111) begin bad++; $display("FAIL midrun_arst_rst_out got=%b exp=1111", rst_out); end
    total++; if (clk_rise !== 4'b0000) begin bad++; $display("FAIL midrun_arst_clk_rise got=%b exp=0000", clk_rise); end
    arst = 1'b0;
    @(negedge clk);
    total++; if (clk_out !== 4'b0000) begin bad++; $display("FAIL midrun_entry_clk_out got=%b exp=0000", clk_out); end
    @(negedge clk);
    total++; if (clk_out !== 4'b1111) begin bad++; $display("FAIL midrun_def_half_clk_out got=%b exp=1111", clk_out); end
    total++; if (clk_rise !== 4'b1111) begin bad++; $display("FAIL midrun_def_half_clk_rise got=%b exp=1111", clk_rise); end
  endtask

  initial begin
    arst     = 1'b1;
    ch_en    = '0;
    cfg_load = '0;
    cfg_half = '0;
    test_reset();
    test_default();
    test_program();
    test_live_change();
    test_stop();
    test_clamp();
    test_midrun_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
